// File: rtl/prog_mem_loadable.sv
// prog_mem_loadable: run-time loadable picoMIPS instruction memory.
// A byte-wide valid/ready link loads the program into the array. The CPU
// is stalled (instr_valid=0) until a load finishes. After that the block
// serves one registered instruction word per clock.
// Optional build macro PROG_MEM_PARITY_EN adds one even-parity bit to each
// stored word and drives par_err. Without the macro, par_err is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------
// HALT  | after reset; no program yet, fetch output held at NOP/invalid
// LOAD  | accepting bytes, assembling and writing words from word 0
// RUN   | serving mem[addr] one cycle later; ld_start starts a reload
module prog_mem_loadable #(
    parameter int IW = 14,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic          par_err,
    input  logic          ld_start,
    input  logic [AW:0]   ld_len,
    input  logic [7:0]    ld_byte,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          busy
);

    localparam int DEPTH = 2 ** AW;
    localparam int NB    = (IW + 7) / 8;

    // DEPTH and 1, held at the width of the length and pointer registers
    localparam logic [AW:0] DEPTH_W  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_W    = {{AW{1'b0}}, 1'b1};
    localparam logic        LAST_IDX = (NB == 2);

`ifdef PROG_MEM_PARITY_EN
    localparam int MW = IW + 1;
`else
    localparam int MW = IW;
`endif

    typedef enum logic [1:0] {
        HALT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [AW:0]   word_ptr;
    logic [AW:0]   word_ptr_inc;
    logic [AW:0]   len_q;
    logic [AW:0]   len_clamp;
    logic          byte_idx;

    logic          load_entry;
    logic          accept;
    logic          last_byte;
    logic          wr_en;
    logic          load_end;
    logic          run_hold;

    logic [IW-1:0] wr_data;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;

    // The array has no reset, so a program survives a CPU reset
    logic [MW-1:0] mem [DEPTH];

    assign busy     = (state == LOAD);
    assign ld_ready = (state == LOAD);

    // Handshake, word-completion and load-termination decode
    always_comb begin
        len_clamp    = (ld_len > DEPTH_W) ? DEPTH_W : ld_len;
        word_ptr_inc = word_ptr + ONE_W;
        last_byte    = (byte_idx == LAST_IDX);
        // With a zero-length load, nothing is accepted during the one LOAD cycle
        accept       = (state == LOAD) && ld_valid && (len_q != '0);
        wr_en        = accept && last_byte;
        load_end     = (state == LOAD) &&
                       ((len_q == '0) || (wr_en && (word_ptr_inc == len_q)));
        load_entry   = (state != LOAD) && (state_nx == LOAD);
        run_hold     = (state == RUN) && (state_nx == RUN);
    end

    // Little-endian byte assembly; bits above IW are discarded
    if (NB == 2) begin : g_two_byte
        logic [7:0] byte_lo;

        // Hold the low byte until the high byte completes the word
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                byte_lo <= '0;
            end else if (accept && !last_byte) begin
                byte_lo <= ld_byte;
            end
        end

        assign wr_data = IW'({ld_byte, byte_lo});
    end else begin : g_one_byte
        assign wr_data = IW'(ld_byte);
    end

`ifdef PROG_MEM_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    assign rd_word = mem[addr];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HALT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; ld_start is ignored while a load is in progress
    always_comb begin
        state_nx = state;
        case (state)
            HALT:    if (ld_start) state_nx = LOAD;
            LOAD:    if (load_end) state_nx = RUN;
            RUN:     if (ld_start) state_nx = LOAD;
            default: state_nx = HALT;
        endcase
    end

    // Load pointers: clear and capture the clamped length on entry, then advance per byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_ptr <= '0;
            byte_idx <= 1'b0;
            len_q    <= '0;
        end else if (load_entry) begin
            word_ptr <= '0;
            byte_idx <= 1'b0;
            len_q    <= len_clamp;
        end else if (accept) begin
            if (last_byte) begin
                word_ptr <= word_ptr_inc;
                byte_idx <= 1'b0;
            end else begin
                byte_idx <= 1'b1;
            end
        end
    end

    // Word write on the edge that accepts the final byte of the word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_ptr[AW-1:0]] <= wr_word;
        end
    end

    // Single-cycle completion pulse on the LOAD -> RUN edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_done <= 1'b0;
        end else begin
            ld_done <= load_end;
        end
    end

    // Registered fetch; NOP/invalid whenever the block is not staying in RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (run_hold) begin
            instr       <= rd_word[IW-1:0];
            instr_valid <= 1'b1;
        end else begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end
    end

`ifdef PROG_MEM_PARITY_EN
    // Parity check registered alongside instr so the flag lines up with its word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err <= 1'b0;
        end else if (run_hold) begin
            par_err <= (^rd_word[IW-1:0]) != rd_word[IW];
        end else begin
            par_err <= 1'b0;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Testbench for prog_mem_loadable (IW=14, AW=5).
module tb_prog_mem_loadable;
    localparam int IW = 14;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          par_err;
    logic          ld_start;
    logic [AW:0]   ld_len;
    logic [7:0]    ld_byte;
    logic          ld_valid;
    logic          ld_ready;
    logic          ld_done;
    logic          busy;

    prog_mem_loadable #(.IW(IW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .addr(addr), .instr(instr),
        .instr_valid(instr_valid), .par_err(par_err),
        .ld_start(ld_start), .ld_len(ld_len), .ld_byte(ld_byte),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic          par;
    } exp_t;

    typedef struct {
        logic [7:0]    b0;
        logic [7:0]    b1;
        logic [IW-1:0] word;
    } ld_vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [IW-1:0] exp;
    } rd_vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          sb[$];
    logic [IW-1:0] model_mem [32];
    logic          model_flip [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW:0] len);
        ld_len   = len;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc      = 1'b0;
        ld_byte  = b;
        ld_valid = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = ld_ready;
            tick();
        end
        ld_valid = 1'b0;
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    // Loads one random word; the upper byte carries junk in bits [7:6]
    task automatic send_rand_word(input int idx);
        logic [IW-1:0] w;
        logic [1:0]    junk;
        w    = IW'($urandom);
        junk = 2'($urandom_range(0, 3));
        send_byte(w[7:0]);
        send_byte({junk, w[13:8]});
        model_mem[idx] = w;
    endtask

    // Drive addr, push expectation; compare after the registered read
    task automatic read_check(input logic [AW-1:0] a);
        exp_t e;
        e.instr = model_mem[a] ^ {{(IW-1){1'b0}}, model_flip[a]};
        e.par   = model_flip[a];
        addr    = a;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check($sformatf("rd_instr@%0d", a), 32'(instr), 32'(e.instr));
        check($sformatf("rd_par@%0d", a), 32'(par_err), 32'(e.par));
        check($sformatf("rd_valid@%0d", a), 32'(instr_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    ld_vec_t t2_ld [3];
    rd_vec_t t2_rd [6];

    initial begin
        int n_acc, n_done, idx, post;
        logic acc;
        logic [7:0] bytes3 [8];

        t2_ld[0] = '{8'h01, 8'h13, 14'h1301};
        t2_ld[1] = '{8'h01, 8'h14, 14'h1401};
        t2_ld[2] = '{8'hA1, 8'h06, 14'h06A1};
        t2_rd[0] = '{5'd1, 14'h1401};
        t2_rd[1] = '{5'd0, 14'h1301};
        t2_rd[2] = '{5'd2, 14'h06A1};
        t2_rd[3] = '{5'd2, 14'h06A1};
        t2_rd[4] = '{5'd1, 14'h1401};
        t2_rd[5] = '{5'd0, 14'h1301};
        for (int i = 0; i < 32; i++) model_flip[i] = 1'b0;

        rst = 1'b0; addr = '0; ld_start = 1'b0; ld_len = '0;
        ld_byte = '0; ld_valid = 1'b0;

        // 1. reset
        #23;
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_ld_done", 32'(ld_done), 32'd0);
        rst = 1'b1;
        repeat (10) tick();
        check("halt_instr_valid", 32'(instr_valid), 32'd0);
        check("halt_instr", 32'(instr), 32'd0);
        check("halt_ld_ready", 32'(ld_ready), 32'd0);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_par_err", 32'(par_err), 32'd0);

        // ld_valid outside LOAD is ignored
        ld_valid = 1'b1; ld_byte = 8'hFF;
        repeat (3) begin
            tick();
            check("halt_valid_ignored", 32'(ld_ready), 32'd0);
        end
        ld_valid = 1'b0;

        // 2. table-driven 3-word load and reads
        start_load(3);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_ld_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            send_byte(t2_ld[i].b0);
            send_byte(t2_ld[i].b1);
            model_mem[i] = t2_ld[i].word;
        end
        check("t2_ld_done", 32'(ld_done), 32'd1);
        check("t2_ready_low", 32'(ld_ready), 32'd0);
        check("t2_valid_not_yet", 32'(instr_valid), 32'd0);
        tick();
        check("t2_ld_done_pulse", 32'(ld_done), 32'd0);
        check("t2_instr_valid", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_model_%0d", i), 32'(model_mem[t2_rd[i].a]), 32'(t2_rd[i].exp));
            read_check(t2_rd[i].a);
        end

        // 3. 4-word load with random ld_valid gaps
        for (int i = 0; i < 4; i++) begin
            logic [IW-1:0] w;
            w = IW'($urandom);
            model_mem[i] = w;
            bytes3[2*i]   = w[7:0];
            bytes3[2*i+1] = {2'($urandom_range(0, 3)), w[13:8]};
        end
        start_load(4);
        n_acc = 0; n_done = 0; idx = 0; post = 0;
        for (int c = 0; c < 200 && post < 6; c++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_byte  = (idx < 8) ? bytes3[idx] : 8'hEE;
            acc      = ld_valid && ld_ready;
            tick();
            if (acc) begin n_acc++; idx++; end
            if (ld_done) n_done++;
            if (idx >= 8) post++;
        end
        ld_valid = 1'b0;
        check("t3_bytes_accepted", 32'(n_acc), 32'd8);
        check("t3_done_pulses", 32'(n_done), 32'd1);
        check("t3_ready_low", 32'(ld_ready), 32'd0);
        for (int i = 0; i < 4; i++) read_check(AW'(i));

        // 4. reset after 3 bytes of a 2-word load
        begin
            logic [IW-1:0] w0;
            w0 = IW'($urandom);
            start_load(2);
            send_byte(w0[7:0]);
            send_byte({2'b00, w0[13:8]});
            send_byte(8'h5A);
            model_mem[0] = w0;
        end
        #2 rst = 1'b0;
        #1;
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_ready", 32'(ld_ready), 32'd0);
        check("t4_rst_valid", 32'(instr_valid), 32'd0);
        #10 rst = 1'b1;
        tick();
        check("t4_halt_busy", 32'(busy), 32'd0);
        // zero-length load, with a byte offered during the single LOAD cycle
        ld_len = '0; ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h55;
        tick();
        ld_start = 1'b0;
        check("t4_len0_busy", 32'(busy), 32'd1);
        check("t4_len0_done_early", 32'(ld_done), 32'd0);
        tick();
        ld_valid = 1'b0;
        check("t4_len0_done", 32'(ld_done), 32'd1);
        check("t4_len0_run", 32'(busy), 32'd0);
        tick();
        check("t4_len0_pulse", 32'(ld_done), 32'd0);
        check("t4_len0_valid", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 4; i++) read_check(AW'(i));

        // 5. over-length load clamps to DEPTH; starts from RUN
        start_load(6'd40);
        tick();
        check("t5_leave_run_valid", 32'(instr_valid), 32'd0);
        check("t5_leave_run_instr", 32'(instr), 32'd0);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin ld_start = 1'b1; ld_len = 6'd1; end
            send_rand_word(i);
            ld_start = 1'b0;
        end
        check("t5_ld_done", 32'(ld_done), 32'd1);
        tick();
        check("t5_ld_done_pulse", 32'(ld_done), 32'd0);
        check("t5_ready_low", 32'(ld_ready), 32'd0);
        for (int i = 0; i < 32; i++) read_check(AW'(i));

`ifdef PROG_MEM_PARITY_EN
        // 6. corrupt one stored data bit of word 2
        dut.mem[2][0] = ~dut.mem[2][0];
        model_flip[2] = 1'b1;
`endif
        read_check(5'd2);
        read_check(5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
